// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, palette and sprite record for the pixel source
package vga_pkg;

    localparam int H_VIS     = 640;
    localparam int V_VIS     = 480;
    localparam int MAP_W     = 40;
    localparam int MAP_H     = 30;
    localparam int TILE_W    = 16;
    localparam int LOOKAHEAD = 2;
    localparam int MAP_SIZE  = MAP_W * MAP_H;

    // Entry 15 is listed first. Index 0 is black so an all-zero map is a blank screen.
    localparam logic [15:0][11:0] PALETTE = {
        12'h444, 12'h880, 12'h808, 12'h088, 12'h800, 12'h080, 12'h008, 12'h888,
        12'hFFF, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF00, 12'h0F0, 12'h00F, 12'h000
    };

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] color;
        logic        en;
    } sprite_t;

endpackage

// File: rtl/tile_ram.sv
// rtl/tile_ram.sv - 1200x4 background tile map with one write port and one registered read port
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port, addresses past the map are dropped;
//        raddr_i read address; rdata_o read data one cycle later, old data on a same-address write.
module tile_ram
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [10:0] waddr_i,
    input  logic [3:0]  wdata_i,
    input  logic [10:0] raddr_i,
    output logic [3:0]  rdata_o
);

    // No reset: contents come from the configuration image (all zeros).
    logic [3:0] mem_q [MAP_SIZE];
    logic [3:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < 11'(MAP_SIZE))) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_source.sv
// rtl/vga_pixel_source.sv - two-stage tile map plus sprite pixel generator for the VGA controller
// Ports: clk/rst pixel clock and async active-high reset; row/col controller scan position;
//        Din registered pixel colour; tm_* tile-map write port; sp_* sprite shadow write port;
//        vblank one-cycle pulse at sprite commit; frame_cnt completed-frame counter.
module vga_pixel_source
    import vga_pkg::*;
#(
    parameter int NSPR   = 4,
    parameter int TILE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    output logic [11:0] Din,
    input  logic        tm_we,
    input  logic [10:0] tm_addr,
    input  logic [3:0]  tm_data,
    input  logic        sp_we,
    input  logic [1:0]  sp_sel,
    input  logic [9:0]  sp_x,
    input  logic [8:0]  sp_y,
    input  logic [11:0] sp_color,
    input  logic        sp_en,
    output logic        vblank,
    output logic [15:0] frame_cnt
);

    logic [9:0]  pc_d, pc_q;
    logic [8:0]  pr_q;
    logic        oob_d, oob_q;
    logic [10:0] rd_addr_d;
    logic [3:0]  tile_idx;
    logic [11:0] din_d, din_q;
    logic        vblank_q;
    logic [15:0] frame_cnt_q;
    logic [8:0]  prev_row_q;
    logic        commit;
    sprite_t     sp_wr;
    sprite_t     shadow_q [NSPR];
    sprite_t     active_q [NSPR];

    // 11-bit right edge so a sprite near column 1023 cannot wrap back onto the left side.
    function automatic logic sprite_hit(sprite_t s, logic [9:0] x, logic [8:0] y);
        return s.en
            && ({1'b0, s.x} <= {1'b0, x}) && ({1'b0, x} < {1'b0, s.x} + 11'(TILE_W))
            && ({1'b0, s.y} <= {1'b0, y}) && ({1'b0, y} < {1'b0, s.y} + 10'(TILE_W));
    endfunction

    tile_ram u_tile_ram (
        .clk_i   (clk),
        .we_i    (tm_we),
        .waddr_i (tm_addr),
        .wdata_i (tm_data),
        .raddr_i (rd_addr_d),
        .rdata_o (tile_idx)
    );

    // Stage 1: look two pixels ahead so the colour lands when the controller samples it.
    always_comb begin
        pc_d      = col + 10'(LOOKAHEAD);
        oob_d     = (pc_d >= 10'(H_VIS)) || (row >= 9'(V_VIS));
        rd_addr_d = oob_d ? 11'd0 : (11'(row[8:4]) * 11'(MAP_W) + 11'(pc_d[9:4]));
        commit    = (row == 9'(V_VIS)) && (prev_row_q != 9'(V_VIS));
        sp_wr     = {sp_x, sp_y, sp_color, sp_en};
    end

    // Stage 2: walk from the highest index down so the lowest hitting sprite wins.
    always_comb begin
        din_d = PALETTE[tile_idx];
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (sprite_hit(active_q[i], pc_q, pr_q)) begin
                din_d = active_q[i].color;
            end
        end
        if (oob_q) begin
            din_d = 12'h000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            pr_q        <= '0;
            oob_q       <= 1'b0;
            din_q       <= '0;
            vblank_q    <= 1'b0;
            frame_cnt_q <= '0;
            prev_row_q  <= '0;
            for (int i = 0; i < NSPR; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            pr_q       <= row;
            oob_q      <= oob_d;
            din_q      <= din_d;
            prev_row_q <= row;
            vblank_q   <= commit;
            // Commit samples the shadow before this cycle's write lands.
            if (commit) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                for (int i = 0; i < NSPR; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (sp_we) begin
                shadow_q[sp_sel] <= sp_wr;
            end
        end
    end

    assign Din       = din_q;
    assign vblank    = vblank_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_source.sv
// tb/tb_vga_pixel_source.sv - self-checking bench for vga_pixel_source
module tb_vga_pixel_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  row = '0;
    logic [9:0]  col = '0;
    logic [11:0] Din;
    logic        tm_we = 1'b0;
    logic [10:0] tm_addr = '0;
    logic [3:0]  tm_data = '0;
    logic        sp_we = 1'b0;
    logic [1:0]  sp_sel = '0;
    logic [9:0]  sp_x = '0;
    logic [8:0]  sp_y = '0;
    logic [11:0] sp_color = '0;
    logic        sp_en = 1'b0;
    logic        vblank;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    vga_pixel_source dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .Din(Din),
        .tm_we(tm_we), .tm_addr(tm_addr), .tm_data(tm_data),
        .sp_we(sp_we), .sp_sel(sp_sel), .sp_x(sp_x), .sp_y(sp_y),
        .sp_color(sp_color), .sp_en(sp_en), .vblank(vblank), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00F, 12'h0F0, 12'hF00, 12'h0FF, 12'hF0F, 12'hFF0, 12'hFFF,
        12'h888, 12'h008, 12'h080, 12'h800, 12'h088, 12'h808, 12'h880, 12'h444
    };

    typedef struct { int x; int y; int color; bit en; } spr_t;

    int          m_tile [1200];
    spr_t        m_shadow [4];
    spr_t        m_active [4];
    int          m_prev, m_frames;
    bit          commit_pend;
    logic [11:0] e0, e1, exp_din;
    bit          v0, v1, exp_ok, exp_vb;
    int          pr0, pc0, pr1, pc1, exp_pr, exp_pc, exp_fc;
    bit          tw_req = 0;
    int          tw_a, tw_d;
    bit          sw_req = 0;
    int          sw_sel;
    spr_t        sw_val;

    function automatic logic [11:0] ref_pixel(int r, int c);
        int pc;
        pc = (c + 2) % 1024;
        if (pc >= 640 || r >= 480) return 12'h000;
        for (int i = 0; i < 4; i++)
            if (m_active[i].en && pc >= m_active[i].x && pc < m_active[i].x + 16 &&
                r >= m_active[i].y && r < m_active[i].y + 16)
                return 12'(m_active[i].color);
        return PAL[m_tile[(r / 16) * 40 + pc / 16]];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = '{0, 0, 0, 1'b0};
            m_active[i] = '{0, 0, 0, 1'b0};
        end
        m_prev = 0; m_frames = 0; commit_pend = 0; v0 = 0; v1 = 0;
    endfunction

    // One pixel clock: exp_* describe what the DUT shows now, then new inputs are driven.
    task automatic tick(input int r, input int c);
        bit commit;
        @(negedge clk);
        exp_din = e1; exp_ok = v1; exp_pr = pr1; exp_pc = pc1;
        e1 = e0; v1 = v0; pr1 = pr0; pc1 = pc0;
        e0 = ref_pixel(r, c); v0 = 1; pr0 = r; pc0 = (c + 2) % 1024;
        exp_vb = commit_pend; exp_fc = m_frames;
        commit = (r == 480) && (m_prev != 480);
        commit_pend = commit; m_prev = r;
        if (commit) begin
            m_frames = (m_frames + 1) % 65536;
            for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        end
        row = r[8:0]; col = c[9:0];
        tm_we = tw_req; tm_addr = tw_a[10:0]; tm_data = tw_d[3:0];
        if (tw_req && tw_a < 1200) m_tile[tw_a] = tw_d;
        sp_we = sw_req; sp_sel = sw_sel[1:0]; sp_x = sw_val.x[9:0]; sp_y = sw_val.y[8:0];
        sp_color = sw_val.color[11:0]; sp_en = sw_val.en;
        if (sw_req) m_shadow[sw_sel] = sw_val;
        tw_req = 0; sw_req = 0;
    endtask

    task automatic do_commit();
        tick(479, 0); tick(480, 0); tick(480, 1); tick(500, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (Din !== 12'h000) begin errors++; $display("FAIL reset_din: got %h expected 000", Din); end
        checks++; if (vblank !== 1'b0) begin errors++; $display("FAIL reset_vblank: got %b expected 0", vblank); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        rst = 1'b0;
        for (int a = 0; a < 1200; a++) begin
            tw_req = 1; tw_a = a; tw_d = 0;
            tick(500, a % 1024);
        end
    endtask

    task automatic test_background();
        int pulses;
        for (int f = 1; f <= 2; f++) begin
            pulses = 0;
            for (int n = 0; n < 330; n++) begin
                if (n < 300) tick(int'($urandom_range(479, 0)), int'($urandom_range(1023, 0)));
                else if (n < 320) tick(480, n);
                else tick(500, n);
                if (exp_ok) begin
                    checks++;
                    if (Din !== 12'h000) begin errors++; $display("FAIL bg_din: pr=%0d pc=%0d got %h expected 000", exp_pr, exp_pc, Din); end
                end
                checks++;
                if (vblank !== exp_vb) begin errors++; $display("FAIL bg_vblank: n=%0d got %b expected %b", n, vblank, exp_vb); end
                if (vblank === 1'b1) pulses++;
            end
            checks++; if (pulses != 1) begin errors++; $display("FAIL bg_pulses: frame %0d got %0d expected 1", f, pulses); end
            checks++; if (frame_cnt !== 16'(f)) begin errors++; $display("FAIL bg_frame_cnt: got %0d expected %0d", frame_cnt, f); end
        end
    endtask

    task automatic test_tile_placement();
        logic [11:0] want;
        tw_req = 1; tw_a = 41; tw_d = 5; tick(500, 0);
        for (int r = 15; r <= 32; r++) begin
            for (int p = 14; p <= 35; p++) begin
                tick(r, (p + 1022) % 1024);
                want = (exp_pr >= 16 && exp_pr <= 31 && exp_pc >= 16 && exp_pc <= 31) ? PAL[5] : PAL[0];
                if (exp_ok) begin
                    checks++;
                    if (Din !== want) begin errors++; $display("FAIL tile_place: pr=%0d pc=%0d got %h expected %h", exp_pr, exp_pc, Din, want); end
                end
            end
        end
    endtask

    task automatic test_lookahead();
        int c;
        tw_req = 1; tw_a = 0; tw_d = 7; tick(500, 0);
        tw_req = 1; tw_a = 1; tw_d = 4; tick(500, 0);
        for (int k = 0; k < 48; k++) begin
            c = (1018 + k) % 1024;
            tick(5, c);
            if (c == 1023 || c == 0 || c == 15 || c == 16 || c == 31 || c == 32) begin
                checks++;
                if (Din !== ((c == 1023) ? 12'h000 : (c == 32) ? PAL[0] : (c < 16) ? PAL[7] : PAL[4])) begin
                    errors++; $display("FAIL lookahead: col=%0d got %h", c, Din);
                end
            end
        end
    endtask

    task automatic test_sprite_commit();
        logic [11:0] want;
        sw_req = 1; sw_sel = 2; sw_val = '{100, 200, 'hF00, 1'b1}; tick(150, 10);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) do_commit();
            for (int r = 199; r <= 216; r++) begin
                for (int p = 99; p <= 118; p++) begin
                    tick(r, (p + 1022) % 1024);
                    want = (pass == 1 && exp_pr >= 200 && exp_pr <= 215 && exp_pc >= 100 && exp_pc <= 115) ? 12'hF00 : 12'h000;
                    if (exp_ok) begin
                        checks++;
                        if (Din !== want) begin errors++; $display("FAIL sprite_commit: pass=%0d pr=%0d pc=%0d got %h expected %h", pass, exp_pr, exp_pc, Din, want); end
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [11:0] want;
        bit in_y;
        sw_req = 1; sw_sel = 0; sw_val = '{630, 300, 'h0F0, 1'b1}; tick(500, 0);
        sw_req = 1; sw_sel = 1; sw_val = '{625, 300, 'h00F, 1'b1}; tick(500, 0);
        do_commit();
        for (int r = 300; r <= 301; r++) begin
            for (int p = 618; p <= 645; p++) begin
                tick(r, (p + 1022) % 1024);
                in_y = (exp_pr >= 300 && exp_pr <= 315);
                want = (in_y && exp_pc >= 625 && exp_pc <= 629) ? 12'h00F :
                       (in_y && exp_pc >= 630 && exp_pc <= 639) ? 12'h0F0 : 12'h000;
                if (exp_ok) begin
                    checks++;
                    if (Din !== want) begin errors++; $display("FAIL priority: pr=%0d pc=%0d got %h expected %h", exp_pr, exp_pc, Din, want); end
                end
            end
        end
    endtask

    task automatic test_collision();
        int rows_l [4] = '{49, 50, 65, 66};
        logic [11:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            tick(479, 0);
            if (pass == 0) begin sw_req = 1; sw_sel = 3; sw_val = '{50, 50, 'h0FF, 1'b1}; end
            tick(480, 0);
            tick(480, 1);
            checks++; if (vblank !== 1'b1) begin errors++; $display("FAIL collision_vblank_hi: got %b expected 1", vblank); end
            tick(500, 0);
            checks++; if (vblank !== 1'b0) begin errors++; $display("FAIL collision_vblank_lo: got %b expected 0", vblank); end
            for (int ri = 0; ri < 4; ri++) begin
                for (int p = 47; p <= 68; p++) begin
                    tick(rows_l[ri], (p + 1022) % 1024);
                    want = (pass == 1 && exp_pr >= 50 && exp_pr <= 65 && exp_pc >= 50 && exp_pc <= 65) ? 12'h0FF : 12'h000;
                    if (exp_ok) begin
                        checks++;
                        if (Din !== want) begin errors++; $display("FAIL collision: pass=%0d pr=%0d pc=%0d got %h expected %h", pass, exp_pr, exp_pc, Din, want); end
                    end
                end
            end
        end
    endtask

    task automatic test_random_pixels();
        int r, c;
        for (int n = 0; n < 400; n++) begin
            if (n % 2 == 0) begin r = int'($urandom_range(70, 0)); c = int'($urandom_range(80, 0)); end
            else begin r = int'($urandom_range(479, 190)); c = int'($urandom_range(1023, 0)); end
            tick(r, c);
            if (exp_ok) begin
                checks++;
                if (Din !== exp_din) begin errors++; $display("FAIL random_pixel: pr=%0d pc=%0d got %h expected %h", exp_pr, exp_pc, Din, exp_din); end
            end
        end
    endtask

    task automatic test_midframe_reset();
        for (int p = 100; p <= 110; p++) tick(200, p - 2);
        checks++; if (Din !== 12'hF00) begin errors++; $display("FAIL prereset_din: got %h expected F00", Din); end
        @(posedge clk); #2; rst = 1'b1; #1;
        checks++; if (Din !== 12'h000) begin errors++; $display("FAIL midreset_din: got %h expected 000", Din); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midreset_frame_cnt: got %0d expected 0", frame_cnt); end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 201; r <= 205; r++) tick(r, 0);
        tick(479, 0); tick(480, 0); tick(480, 1);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL postreset_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (vblank !== 1'b1) begin errors++; $display("FAIL postreset_vblank: got %b expected 1", vblank); end
        tick(500, 0);
        for (int p = 98; p <= 114; p++) begin
            tick(205, p - 2);
            if (exp_ok && exp_pr == 205) begin
                checks++;
                if (Din !== 12'h000) begin errors++; $display("FAIL postreset_sprite: pc=%0d got %h expected 000", exp_pc, Din); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_background();
        test_tile_placement();
        test_lookahead();
        test_sprite_commit();
        test_priority();
        test_collision();
        test_random_pixels();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_pixel_source.md
# vga_pixel_source

Pixel-generation stage feeding the VGA timing controller's 12-bit `Din`. It maps the controller's registered `row`/`col` to a colour using a 40x30 background tile map and four solid 16x16 sprites, through a two-stage pipeline. It compensates for its own latency so each colour arrives exactly when the controller samples it. Game logic updates the tile map directly; sprite state is double-buffered and committed only at the start of vertical blank.

## Interface
- `NSPR`, 4: sprite count; fixed, sized for a 2-bit select.
- `TILE_W`, 16: tile and sprite edge in pixels.
- `clk` in 1: pixel clock, same clock as the VGA controller.
- `rst` in 1: reset; asynchronous, active-high.
- `row` in 9: controller row address, 0..479 visible.
- `col` in 10: controller column address, 0..639 visible, wraps mod 1024.
- `Din` out 12: pixel colour; [3:0]=R, [7:4]=G, [11:8]=B.
- `tm_we` in 1: tile-map write strobe.
- `tm_addr` in 11: tile index = ty*40+tx; values 1200..2047 are ignored.
- `tm_data` in 4: palette index.
- `sp_we` in 1: sprite shadow write strobe.
- `sp_sel` in 2: sprite number.
- `sp_x` in 10, `sp_y` in 9: sprite top-left corner.
- `sp_color` in 12: sprite colour.
- `sp_en` in 1: sprite enable.
- `vblank` out 1: one-cycle pulse at the commit point.
- `frame_cnt` out 16: completed-frame counter; wraps at 65535→0.

## Operation
- **Lookahead:** the effective coordinate is pc = (col + 2) mod 1024 and pr = row.
  - The two-cycle latency plus the controller's one-cycle sampling delay makes `Din` match the controller's current pixel.
  - Example: `col`=0x3FE yields pc=0.
- **Stage 1:**
  - Registers pc and pr.
  - Issues a synchronous tile-RAM read at (pr>>4)*40 + (pc>>4).
  - Clamps the address to 0 when pc≥640 or pr≥480, and sets an `oob` flag.
- **Stage 2:**
  - Palette lookup of the tile data gives the background colour.
  - Sprite hit test for sprite i: `en` set, and x ≤ pc < x+16, and y ≤ pr < y+16.
  - Comparisons use 11-bit arithmetic, so x+16 never wraps. A sprite at x=630 is clipped naturally.
  - The lowest-index hitting sprite wins.
  - `oob` forces 0x000.
  - Result is registered into `Din`.
- **Tile RAM:**
  - 1200×4, one write port and one read port.
  - Not cleared by `rst`; initialised to all zeros at configuration.
  - A write to the address being read in the same cycle returns the old data.
- **Sprite registers:**
  - `sp_we` writes the shadow entry `sp_sel`.
  - The active set is what stage 2 uses.
  - Commit copies shadow → active for all four sprites.
  - If `sp_we` and commit occur in the same cycle, the commit copies the pre-write shadow. The new value becomes active at the next commit.
- **Commit point:**
  - Occurs on the first cycle where `row`==480 and the previous registered `row` ≠480.
  - In that cycle: `vblank`=1 and `frame_cnt` increments.
  - Happens exactly once per frame.

## Timing
- Reset values:
  - `Din`=0x000, `vblank`=0, `frame_cnt`=0.
  - Shadow and active sprites: all fields 0, `en`=0.
  - Pipeline registers and the previous-row register: 0.
- Reset mid-frame clears outputs immediately. After release, the first commit occurs at the next row 0→480 edge.
- Latency: `row`/`col` at edge k → `Din` valid after edge k+2.
- Writes:
  - A tile write is visible to reads issued from the next cycle.
  - A sprite write becomes active only at a commit.
- `vblank` goes high the cycle after `row` becomes 480 and stays high for exactly 1 cycle.
- Throughput: one pixel per clock; no stalls; no handshake on the write ports (fire-and-forget).

## Structure
- Package `vga_pkg` holds:
  - Constants H_VIS=640, V_VIS=480, MAP_W=40, MAP_H=30, TILE_W=16, LOOKAHEAD=2.
  - The 16-entry 12-bit palette constant (index 0 = 0x000).
  - The sprite record typedef {x[9:0], y[8:0], color[11:0], en}.
- Sub-module `tile_ram` (1200×4, sync read, write-first disallowed, i.e. read-old) so it infers block RAM.
- Everything else stays in `vga_pixel_source`.

## Test plan
- **Reset and background:**
  - Stimulus: reset; fill the tile map with index 0; drive `row`/`col` from a VGA timing model.
  - Required: `Din`=0x000 everywhere; `vblank` pulses once per 800×525 cycles; `frame_cnt` goes 0→1→2.
- **Tile placement:**
  - Stimulus: tile 41 (tx=1, ty=1) = palette index 5.
  - Required: exactly the pixels pc 16..31, pr 16..31 show palette[5]; pixel (15,16) shows palette[0].
- **Lookahead alignment:**
  - Stimulus: tile 0 = nonzero colour.
  - Required: the controller-sampled pixel at `col`=0 equals palette value; the sample at `col`=16 uses tile 1.
- **Sprite commit:**
  - Stimulus: write sprite 2 {x=100, y=200, color=0xF00, en=1} mid-frame.
  - Required: no change in the current frame; from the next frame, pixels (100..115, 200..215) are 0xF00.
- **Priority and clipping:**
  - Stimulus: sprite 0 at x=630 colour 0x0F0, sprite 1 at x=625 colour 0x00F, same y.
  - Required: pc 625..629 show 0x00F, pc 630..639 show 0x0F0, nothing drawn at pc ≥640.
- **Write/commit collision and mid-frame reset:**
  - Stimulus: `sp_we` in the commit cycle.
  - Required: the value is not active until the following commit.
  - Stimulus: assert `rst` at row 200.
  - Required: `Din`=0 and `frame_cnt`=0 immediately.
